// File: rtl/chacha_stream_driver_if.sv
// Request/response bundle between the stream driver (master) and chacha_core (slave).
interface chacha_stream_driver_if;
  localparam int unsigned KEY_W = 256;
  localparam int unsigned IV_W  = 64;
  localparam int unsigned CTR_W = 64;
  localparam int unsigned BLK_W = 512;

  logic             core_init;
  logic             core_next;
  logic [KEY_W-1:0] core_key;
  logic [IV_W-1:0]  core_iv;
  logic [CTR_W-1:0] core_ctr;
  logic [BLK_W-1:0] core_data_in;
  logic             core_ready;
  logic             core_data_out_valid;
  logic [BLK_W-1:0] core_data_out;

  modport master (
    output core_init, core_next, core_key, core_iv, core_ctr, core_data_in,
    input  core_ready, core_data_out_valid, core_data_out
  );

  modport slave (
    input  core_init, core_next, core_key, core_iv, core_ctr, core_data_in,
    output core_ready, core_data_out_valid, core_data_out
  );
endinterface

// File: rtl/chacha_stream_driver.sv
// chacha_stream_driver: packs a 32-bit word stream into 512-bit blocks, drives
// chacha_core over init/next/ready/data_out_valid (init for the first block of
// a message, next afterwards) and unpacks each result into a 32-bit stream.
// Optional feature macro: CHACHA_STREAM_WDOG_EN (bounded WAIT, sticky wdog_err).
module chacha_stream_driver #(
  parameter logic [63:0] CTR_STEP    = 64'd1,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [255:0]           key,
  input  logic [63:0]            iv,
  input  logic [63:0]            ctr0,
  output logic                   busy,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [31:0]            s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [31:0]            m_data,
  output logic                   m_last,
  chacha_stream_driver_if.master core,
  output logic                   wdog_err
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BLK_W  = 512;
  localparam int unsigned KEY_W  = 256;
  localparam int unsigned CTR_W  = 64;
  localparam int unsigned IDX_W  = 4;
  localparam int unsigned NW_W   = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_ISSUE,
    S_WAIT,
    S_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic               busy_q, busy_d;
  logic               s_ready_q, s_ready_d;
  logic               m_valid_q, m_valid_d;
  logic [WORD_W-1:0]  m_data_q, m_data_d;
  logic               m_last_q, m_last_d;
  logic               init_q, init_d;
  logic               next_q, next_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [CTR_W-1:0]   iv_q, iv_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic [BLK_W-1:0]   res_q, res_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   oidx_q, oidx_d;
  logic [NW_W-1:0]    nwords_q, nwords_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic               blk_end_c;

`ifdef CHACHA_STREAM_WDOG_EN
  localparam int unsigned WDOG_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  logic [WDOG_W-1:0]  wdog_cnt_q, wdog_cnt_d;
  logic               wdog_err_q, wdog_err_d;
`endif

  // Word k of a block lives at bits [511-32k -: 32].
  function automatic logic [WORD_W-1:0] word_of(input logic [BLK_W-1:0] blk,
                                                input logic [IDX_W-1:0] k);
    return blk[(BLK_W - WORD_W) - WORD_W * 32'(k) +: WORD_W];
  endfunction

  function automatic logic [BLK_W-1:0] put_word(input logic [BLK_W-1:0]  blk,
                                                input logic [IDX_W-1:0]  k,
                                                input logic [WORD_W-1:0] w);
    logic [BLK_W-1:0] r;
    r = blk;
    r[(BLK_W - WORD_W) - WORD_W * 32'(k) +: WORD_W] = w;
    return r;
  endfunction

  assign blk_end_c = ({1'b0, oidx_q} == (nwords_q - NW_W'(1)));

  // Next-state and next-output logic for the whole datapath.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    s_ready_d = s_ready_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    init_d    = 1'b0;
    next_d    = 1'b0;
    key_d     = key_q;
    iv_d      = iv_q;
    ctr_d     = ctr_q;
    blk_d     = blk_q;
    res_d     = res_q;
    idx_d     = idx_q;
    oidx_d    = oidx_q;
    nwords_d  = nwords_q;
    first_d   = first_q;
    last_d    = last_q;
`ifdef CHACHA_STREAM_WDOG_EN
    wdog_cnt_d = wdog_cnt_q;
    wdog_err_d = wdog_err_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          key_d     = key;
          iv_d      = iv;
          ctr_d     = ctr0;
          first_d   = 1'b1;
          last_d    = 1'b0;
          busy_d    = 1'b1;
          s_ready_d = 1'b1;
          blk_d     = '0;
          idx_d     = '0;
          state_d   = S_FILL;
`ifdef CHACHA_STREAM_WDOG_EN
          wdog_err_d = 1'b0;
`endif
        end
      end

      S_FILL: begin
        if (s_valid && s_ready_q) begin
          blk_d = put_word(blk_q, idx_q, s_data);
          idx_d = idx_q + IDX_W'(1);
          if (s_last || (idx_q == IDX_W'(15))) begin
            s_ready_d = 1'b0;
            last_d    = s_last;
            nwords_d  = {1'b0, idx_q} + NW_W'(1);
            state_d   = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        if (core.core_ready) begin
          init_d  = first_q;
          next_d  = !first_q;
          first_d = 1'b0;
          state_d = S_WAIT;
`ifdef CHACHA_STREAM_WDOG_EN
          wdog_cnt_d = '0;
`endif
        end
      end

      S_WAIT: begin
        if (core.core_data_out_valid) begin
          res_d     = core.core_data_out;
          m_valid_d = 1'b1;
          m_data_d  = word_of(core.core_data_out, IDX_W'(0));
          m_last_d  = last_q && (nwords_q == NW_W'(1));
          oidx_d    = '0;
          state_d   = S_DRAIN;
        end
`ifdef CHACHA_STREAM_WDOG_EN
        else if (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1)) begin
          wdog_err_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end else begin
          wdog_cnt_d = wdog_cnt_q + WDOG_W'(1);
        end
`endif
      end

      S_DRAIN: begin
        if (m_ready) begin
          if (blk_end_c) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            m_data_d  = '0;
            ctr_d     = ctr_q + CTR_STEP;
            idx_d     = '0;
            if (last_q) begin
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end else begin
              s_ready_d = 1'b1;
              blk_d     = '0;
              state_d   = S_FILL;
            end
          end else begin
            oidx_d   = oidx_q + IDX_W'(1);
            m_data_d = word_of(res_q, oidx_q + IDX_W'(1));
            m_last_d = last_q && (({1'b0, oidx_q} + NW_W'(2)) == nwords_q);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset discards any message in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      init_q    <= 1'b0;
      next_q    <= 1'b0;
      key_q     <= '0;
      iv_q      <= '0;
      ctr_q     <= '0;
      blk_q     <= '0;
      res_q     <= '0;
      idx_q     <= '0;
      oidx_q    <= '0;
      nwords_q  <= '0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
`ifdef CHACHA_STREAM_WDOG_EN
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      init_q    <= init_d;
      next_q    <= next_d;
      key_q     <= key_d;
      iv_q      <= iv_d;
      ctr_q     <= ctr_d;
      blk_q     <= blk_d;
      res_q     <= res_d;
      idx_q     <= idx_d;
      oidx_q    <= oidx_d;
      nwords_q  <= nwords_d;
      first_q   <= first_d;
      last_q    <= last_d;
`ifdef CHACHA_STREAM_WDOG_EN
      wdog_cnt_q <= wdog_cnt_d;
      wdog_err_q <= wdog_err_d;
`endif
    end
  end

  assign busy              = busy_q;
  assign s_ready           = s_ready_q;
  assign m_valid           = m_valid_q;
  assign m_data            = m_data_q;
  assign m_last            = m_last_q;
  assign core.core_init    = init_q;
  assign core.core_next    = next_q;
  assign core.core_key     = key_q;
  assign core.core_iv      = iv_q;
  assign core.core_ctr     = ctr_q;
  assign core.core_data_in = blk_q;

`ifdef CHACHA_STREAM_WDOG_EN
  assign wdog_err = wdog_err_q;
`else
  // No watchdog: flag is permanently low whatever WDOG_CYCLES is set to.
  assign wdog_err = (WDOG_CYCLES == 0) && 1'b0;
`endif

endmodule

// File: tb/tb_chacha_stream_driver.sv
// Bench for chacha_stream_driver: a 10-cycle core stub (keystream word k =
// ctr[31:0]^k, xored onto data_in) plus a message-level reference model.
module tb_chacha_stream_driver;
  localparam int unsigned WDOG_CYCLES = 64;
  localparam int unsigned STUB_LAT    = 10;
  localparam logic [63:0] CTR_STEP    = 64'd1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [255:0] key = '0;
  logic [63:0]  iv = '0;
  logic [63:0]  ctr0 = '0;
  logic         busy;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [31:0]  s_data = '0;
  logic         s_last = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic [31:0]  m_data;
  logic         m_last;
  logic         wdog_err;

  chacha_stream_driver_if core_if();

  chacha_stream_driver #(.CTR_STEP(CTR_STEP), .WDOG_CYCLES(WDOG_CYCLES)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .key(key), .iv(iv), .ctr0(ctr0),
    .busy(busy), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .core(core_if), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0]  msg_w [64];
  int           msg_n;
  logic [255:0] mdl_key;
  logic [63:0]  mdl_iv;
  logic [31:0]  exp_data [$];
  bit           exp_last [$];
  logic [63:0]  req_ctr [$];
  bit           req_init [$];
  logic [511:0] req_blk [$];
  logic [31:0]  got_log [$];
  int           last_pos;

  // Stub bookkeeping
  int           stub_silent = 0;
  int           req_seen = 0;
  int           n_init = 0;
  int           n_next = 0;
  logic [63:0]  last_req_ctr;
  logic [511:0] last_req_blk;

  int rdy_mode = 0;
  int rdy_ph = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Expected requests and output words for the message held in msg_w.
  task automatic model_msg(input logic [63:0] c0);
    int nblk;
    nblk = (msg_n + 15) / 16;
    for (int b = 0; b < nblk; b++) begin
      logic [63:0]  c;
      logic [511:0] blk;
      int           cnt;
      c   = c0 + 64'(b) * CTR_STEP;
      blk = '0;
      cnt = (msg_n - 16 * b > 16) ? 16 : msg_n - 16 * b;
      for (int i = 0; i < cnt; i++) begin
        blk[511 - 32 * i -: 32] = msg_w[16 * b + i];
        exp_data.push_back(msg_w[16 * b + i] ^ c[31:0] ^ 32'(i));
        exp_last.push_back((16 * b + i) == (msg_n - 1));
      end
      req_ctr.push_back(c);
      req_init.push_back(b == 0);
      req_blk.push_back(blk);
    end
  endtask

  task automatic flush_model();
    exp_data.delete();
    exp_last.delete();
    req_ctr.delete();
    req_init.delete();
    req_blk.delete();
  endtask

  task automatic fill_msg(input int n, input bit zero);
    msg_n = n;
    for (int i = 0; i < n; i++) msg_w[i] = zero ? 32'h0 : $urandom();
  endtask

  function automatic logic [255:0] rand_key();
    logic [255:0] k;
    for (int j = 0; j < 8; j++) k[32 * j +: 32] = $urandom();
    return k;
  endfunction

  task automatic send_msg(input logic [63:0] c0, input logic [255:0] k,
                          input logic [63:0] v, input int gap);
    mdl_key = k;
    mdl_iv  = v;
    model_msg(c0);
    @(posedge clk); #1;
    key = k; iv = v; ctr0 = c0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < msg_n; i++) begin
      bit hs;
      int t;
      while (int'($urandom_range(0, 99)) < gap) begin
        s_valid = 1'b0;
        @(posedge clk); #1;
      end
      s_valid = 1'b1;
      s_data  = msg_w[i];
      s_last  = (i == msg_n - 1);
      t = 0;
      do begin
        @(negedge clk);
        hs = s_ready;
        @(posedge clk); #1;
        t++;
      end while (!hs && t < 2000);
      if (!hs) begin
        checks++; errors++;
        $display("FAIL s_accept_timeout: word %0d not accepted, got s_ready=0 required 1", i);
        break;
      end
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while ((busy || exp_data.size() != 0) && t < 5000) begin
      @(posedge clk); #1;
      t++;
    end
    check({name, "_done"}, 64'(t < 5000), 64'd1);
    check({name, "_req_left"}, 64'(req_ctr.size()), 64'd0);
    check({name, "_mvalid_idle"}, 64'(m_valid), 64'd0);
  endtask

  // Core stub: checks each request against the model and answers after STUB_LAT cycles.
  initial begin
    bit           pending;
    int           lat;
    logic [511:0] sblk;
    logic [63:0]  sctr;
    pending = 0;
    lat = 0;
    core_if.core_ready          = 1'b1;
    core_if.core_data_out_valid = 1'b0;
    core_if.core_data_out       = '0;
    forever begin
      @(posedge clk); #1;
      core_if.core_data_out_valid = 1'b0;
      if (!reset_n) begin
        pending = 0;
        core_if.core_ready = 1'b1;
      end else if (core_if.core_init || core_if.core_next) begin
        req_seen++;
        if (core_if.core_init) n_init++;
        if (core_if.core_next) n_next++;
        last_req_ctr = core_if.core_ctr;
        last_req_blk = core_if.core_data_in;
        check("req_single_pulse", 64'(core_if.core_init && core_if.core_next), 64'd0);
        if (req_ctr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req: got request ctr=%h required none", core_if.core_ctr);
        end else begin
          check("req_init", 64'(core_if.core_init), 64'(req_init[0]));
          check("req_ctr", core_if.core_ctr, req_ctr[0]);
          check("req_key", 64'(core_if.core_key == mdl_key), 64'd1);
          check("req_iv", core_if.core_iv, mdl_iv);
          check("req_data_in", 64'(core_if.core_data_in == req_blk[0]), 64'd1);
          void'(req_ctr.pop_front());
          void'(req_init.pop_front());
          void'(req_blk.pop_front());
        end
        if (stub_silent == 0) begin
          pending = 1;
          lat = STUB_LAT;
          core_if.core_ready = 1'b0;
          sblk = core_if.core_data_in;
          sctr = core_if.core_ctr;
        end
      end else if (pending) begin
        lat--;
        if (lat <= 0) begin
          for (int k = 0; k < 16; k++)
            core_if.core_data_out[511 - 32 * k -: 32] = sblk[511 - 32 * k -: 32] ^ sctr[31:0] ^ 32'(k);
          core_if.core_data_out_valid = 1'b1;
          core_if.core_ready = 1'b1;
          pending = 0;
        end
      end
    end
  end

  // Output-side ready pattern.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1: begin m_ready = (rdy_ph == 0); rdy_ph = (rdy_ph + 1) % 3; end
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Compare process: every valid output word against the model head.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && m_valid) begin
        check("s_ready_in_drain", 64'(s_ready), 64'd0);
        if (exp_data.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got m_data=%h required no output", m_data);
        end else begin
          check("m_data", 64'(m_data), 64'(exp_data[0]));
          check("m_last", 64'(m_last), 64'(exp_last[0]));
          if (m_ready) begin
            got_log.push_back(m_data);
            if (m_last) last_pos = got_log.size() - 1;
            void'(exp_data.pop_front());
            void'(exp_last.pop_front());
          end
        end
      end
    end
  end

  initial begin
    int n0, x0, t;
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_m_valid", 64'(m_valid), 64'd0);
    check("rst_m_data", 64'(m_data), 64'd0);
    check("rst_core_init", 64'(core_if.core_init), 64'd0);
    check("rst_core_ctr", core_if.core_ctr, 64'd0);
    check("rst_data_in", 64'(core_if.core_data_in == '0), 64'd1);
    check("rst_wdog_err", 64'(wdog_err), 64'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // 1: 32 zero words, all-zero key/iv/ctr0
    got_log.delete(); n0 = n_init; x0 = n_next;
    fill_msg(32, 1);
    send_msg(64'd0, '0, 64'd0, 0);
    wait_idle("t1");
    check("t1_n_init", 64'(n_init - n0), 64'd1);
    check("t1_n_next", 64'(n_next - x0), 64'd1);
    check("t1_ctr2", last_req_ctr, 64'd1);
    check("t1_nout", 64'(got_log.size()), 64'd32);
    if (got_log.size() == 32) begin
      check("t1_w0", 64'(got_log[0]), 64'h0);
      check("t1_w16", 64'(got_log[16]), 64'h1);
      check("t1_w17", 64'(got_log[17]), 64'h0);
      check("t1_w31", 64'(got_log[31]), 64'hE);
    end
    check("t1_last_pos", 64'(last_pos), 64'd31);

    // 2: 5-word message
    got_log.delete();
    fill_msg(5, 0);
    send_msg({$urandom(), $urandom()}, rand_key(), {$urandom(), $urandom()}, 20);
    wait_idle("t2");
    check("t2_pad_zero", 64'(last_req_blk[351:0] == '0), 64'd1);
    check("t2_nout", 64'(got_log.size()), 64'd5);
    check("t2_last_pos", 64'(last_pos), 64'd4);

    // 3: m_ready 1-of-3 during drain, 40 words
    got_log.delete(); rdy_mode = 1;
    fill_msg(40, 0);
    send_msg({$urandom(), $urandom()}, rand_key(), {$urandom(), $urandom()}, 30);
    wait_idle("t3");
    check("t3_nout", 64'(got_log.size()), 64'd40);
    check("t3_last_pos", 64'(last_pos), 64'd39);

    // 4: counter wrap across two full blocks
    got_log.delete(); rdy_mode = 2;
    fill_msg(32, 0);
    send_msg(64'hFFFF_FFFF_FFFF_FFFF, rand_key(), {$urandom(), $urandom()}, 10);
    wait_idle("t4");
    check("t4_ctr_wrap", last_req_ctr, 64'd0);
    check("t4_nout", 64'(got_log.size()), 64'd32);

    // Randomized messages
    for (int m = 0; m < 8; m++) begin
      got_log.delete();
      rdy_mode = int'($urandom_range(0, 2));
      fill_msg(int'($urandom_range(1, 40)), 0);
      send_msg({$urandom(), $urandom()}, rand_key(), {$urandom(), $urandom()},
               int'($urandom_range(0, 50)));
      wait_idle("rand");
      check("rand_nout", 64'(got_log.size()), 64'(msg_n));
    end
    rdy_mode = 0;

    // 5: reset while waiting on the core
    stub_silent = 1;
    n0 = req_seen;
    fill_msg(3, 0);
    send_msg({$urandom(), $urandom()}, rand_key(), {$urandom(), $urandom()}, 0);
    t = 0;
    while (req_seen == n0 && t < 100) begin @(negedge clk); t++; end
    check("t5_req_seen", 64'(req_seen != n0), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_m_valid", 64'(m_valid), 64'd0);
    check("t5_core_ctr", core_if.core_ctr, 64'd0);
    flush_model();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    stub_silent = 0;
    got_log.delete(); n0 = n_init;
    fill_msg(4, 0);
    send_msg({$urandom(), $urandom()}, rand_key(), {$urandom(), $urandom()}, 0);
    wait_idle("t5");
    check("t5_new_init", 64'(n_init - n0), 64'd1);
    check("t5_nout", 64'(got_log.size()), 64'd4);

`ifdef CHACHA_STREAM_WDOG_EN
    // 6: core never answers
    stub_silent = 1;
    n0 = req_seen;
    fill_msg(2, 0);
    send_msg({$urandom(), $urandom()}, rand_key(), {$urandom(), $urandom()}, 0);
    t = 0;
    while (req_seen == n0 && t < 100) begin @(negedge clk); t++; end
    check("t6_req_seen", 64'(req_seen != n0), 64'd1);
    t = 0;
    while (!wdog_err && t < 4 * WDOG_CYCLES) begin @(negedge clk); t++; end
    check("t6_wdog_delay", 64'(t), 64'(WDOG_CYCLES));
    check("t6_busy", 64'(busy), 64'd0);
    repeat (4) @(negedge clk);
    check("t6_sticky", 64'(wdog_err), 64'd1);
    check("t6_no_out", 64'(got_log.size()), 64'd0);
    flush_model();
    stub_silent = 0;
    got_log.delete();
    fill_msg(3, 0);
    send_msg({$urandom(), $urandom()}, rand_key(), {$urandom(), $urandom()}, 0);
    check("t6_cleared", 64'(wdog_err), 64'd0);
    wait_idle("t6");
    check("t6_nout", 64'(got_log.size()), 64'd3);
`else
    check("wdog_tied_low", 64'(wdog_err), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #800000;
    $display("FAIL global_timeout: got no finish, required finish before limit");
    $fatal(1, "global timeout");
  end

endmodule
